// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) engine.
// One iteration per cycle, WIDTH iterations per op, one-cycle completion pulse.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int               CNT_W   = 6;
  localparam int               PW      = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [PW-1:0]    prod_q, prod_d;   // {acc[WIDTH:0], multiplier, guard}
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  logic start, start_div, div_zero, last_iter;

  assign start     = (state_q != BUSY) && (ctrl_MULT || ctrl_DIV);
  assign start_div = start && !ctrl_MULT;
  assign div_zero  = start_div && (data_operandB == '0);
  assign last_iter = (state_q == BUSY) && (cnt_q == LAST);

  logic [WIDTH:0]     acc, acc_sum, mcand_ext, rem_shift, rem_step;
  logic [PW-1:0]      prod_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo_step, a_mag, b_mag;

  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_comb begin : iterate
    acc       = prod_q[PW-1 -: WIDTH+1];
    mcand_ext = {opb_q[WIDTH-1], opb_q};
    case (prod_q[1:0])
      2'b01:   acc_sum = acc + mcand_ext;
      2'b10:   acc_sum = acc - mcand_ext;
      default: acc_sum = acc;
    endcase
    prod_step = {acc_sum[WIDTH], acc_sum, prod_q[WIDTH:1]};
    product   = prod_step[2*WIDTH:1];

    // The sign of the partial remainder picks subtract or add-back each step.
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_step  = rem_q[WIDTH] ? rem_shift + {1'b0, opb_q} : rem_shift - {1'b0, opb_q};
    quo_step  = {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (div_zero)   state_d = DONE;
        else if (start) state_d = BUSY;
        else            state_d = IDLE;
      end
      BUSY:    state_d = last_iter ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath
    // NOTE: every _d starts from its _q so no branch leaves a value unassigned (no latch).
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    res_d    = res_q;
    exc_d    = exc_q;
    if (start) begin
      cnt_d    = '0;
      op_div_d = start_div;
      if (start_div) begin
        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        ovf_d = (data_operandA == INT_MIN) && (&data_operandB);
        opb_d = b_mag;
        rem_d = '0;
        quo_d = a_mag;
        if (div_zero) begin
          res_d = '0;
          exc_d = 1'b1;
        end
      end else begin
        opb_d  = data_operandA;
        prod_d = {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      end
    end else if (state_q == BUSY) begin
      cnt_d = last_iter ? '0 : cnt_q + CNT_W'(1);
      if (op_div_q) begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (last_iter) begin
          res_d = neg_q ? -quo_step : quo_step;
          exc_d = ovf_q;
        end
      end else begin
        prod_d = prod_step;
        if (last_iter) begin
          res_d = product[WIDTH-1:0];
          exc_d = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: datapath registers are reset as well, so results read 0 after an abort.
  always_ff @(posedge clk or posedge reset) begin : datapath_reg
    if (reset) begin
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      opb_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin : outputs
    data_resultRDY = (state_q == DONE);
    busy           = (state_q == BUSY);
    data_result    = res_q;
    data_exception = exc_q;
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: the driver pushes reference results,
// a negedge monitor pops and compares them whenever a completion pulse appears.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] opA, opB;
  logic [31:0] result;
  logic        exc, rdy, busy;

  always #5 clk = ~clk;

  multdiv_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (result),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] res;
    bit          exc;
    int          when;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: signed arithmetic on wide integers, straight from the rules.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e);
    longint p;
    int     q;
    if (!is_div) begin
      p = longint'(int'(a)) * longint'(int'(b));
      r = p[31:0];
      e = (p != longint'(int'(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = int'(a) / int'(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return 32'(0 - $urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    exp_t        e;
    logic [31:0] r;
    bit          x;
    bit          dz;
    model(is_div, a, b, r, x);
    dz        = is_div && (b == 32'd0);
    ctrl_MULT = !is_div;
    ctrl_DIV  = is_div;
    opA       = a;
    opB       = b;
    e.res     = r;
    e.exc     = x;
    e.when    = cyc + (dz ? 1 : 33);
    e.name    = name;
    sb.push_back(e);
    @(negedge clk);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    opA       = $urandom;
    opB       = $urandom;
    check({name, "_busy"}, busy, dz ? 1'b0 : 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", rdy, 1'b0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_exc"}, exc, e.exc);
        check({e.name, "_latency"}, cyc, e.when);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int gap;
    bit is_div;
    reset     = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    opA       = '0;
    opB       = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_exc", exc, 1'b0);
    check("rst_rdy", rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    start_op(1'b0, 32'd7, 32'hFFFF_FFFA, "mul_7xm6");           wait_done("mul_7xm6");   @(negedge clk);
    start_op(1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");    wait_done("mul_ovf");    @(negedge clk);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");           wait_done("div_m7_2");   @(negedge clk);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin"); wait_done("div_intmin"); @(negedge clk);
    start_op(1'b1, 32'd5, 32'd0, "div_by_zero");                wait_done("div_by_zero"); @(negedge clk);

    // A DIV start in the middle of a MULT must be ignored.
    start_op(1'b0, 32'd5, 32'd3, "mul_ignore_div");
    repeat (9) @(negedge clk);
    ctrl_DIV = 1'b1;
    opA      = 32'd9;
    opB      = 32'd3;
    @(negedge clk);
    ctrl_DIV = 1'b0;
    wait_done("mul_ignore_div");
    @(negedge clk);

    // Back-to-back: DIV started in the DONE cycle of a MULT.
    start_op(1'b0, 32'd123, 32'hFFFF_FFD3, "b2b_mul");
    wait_done("b2b_mul");
    start_op(1'b1, 32'd100, 32'd7, "b2b_div");
    wait_done("b2b_div");
    @(negedge clk);

    // Abort a MULT with an asynchronous reset.
    start_op(1'b0, 32'd1234, 32'd5678, "mul_abort");
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_exc", exc, 1'b0);
    check("abort_rdy", rdy, 1'b0);
    check("abort_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    start_op(1'b0, 32'd3, 32'd3, "mul_3x3");
    wait_done("mul_3x3");
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      is_div = 1'($urandom_range(0, 1));
      start_op(is_div, pick(), pick(), $sformatf("rand%0d", i));
      wait_done($sformatf("rand%0d", i));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
